// File: rtl/maindec_ws.sv
// Multicycle MIPS main decoder with wait-state support on memory-access states.
// Memory states (FETCH, MEMRD, MEMWR) hold until done, from a wait counter or mem_ready.
module maindec_ws #(
    parameter int MEM_WAIT  = 0,
    parameter int USE_READY = 0,
    parameter int EXC_EN    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       memread,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       regwrite,
    output logic       alusrca,
    output logic       branch,
    output logic       bne,
    output logic       epcwrite,
    output logic       causewrite,
    output logic [2:0] alusrcb,
    output logic [1:0] regdst,
    output logic [1:0] memtoreg,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic [1:0] lb,
    output logic       busy,
    output logic [3:0] st
);
    localparam int CW = (MEM_WAIT < 1) ? 1 : $clog2(MEM_WAIT + 1);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_LB   = 6'b100000;
    localparam logic [5:0] OP_LBU  = 6'b100100;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB = 4'd7,
        S_BRANCH = 4'd8,  S_IEXEC  = 4'd9,  S_IWB    = 4'd10, S_JUMP  = 4'd11,
        S_JAL    = 4'd12, S_EXC    = 4'd13
    } state_t;

    state_t        state, next;
    logic [CW-1:0] cnt;
    logic          done, mem_state;
    logic [1:0]    lb_sel;

    assign mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign done      = (USE_READY != 0) ? mem_ready : (cnt == CW'(MEM_WAIT));
    assign busy      = mem_state & ~done;
    assign st        = state;
    assign lb_sel    = (op == OP_LB) ? 2'b01 : ((op == OP_LBU) ? 2'b10 : 2'b00);

    always_comb begin
        next = S_FETCH;
        case (state)
            S_FETCH:  next = done ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_R:                      next = S_EXEC;
                    OP_LW, OP_SW, OP_LB, OP_LBU: next = S_MEMADR;
                    OP_BEQ, OP_BNE:            next = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI:  next = S_IEXEC;
                    OP_J:                      next = S_JUMP;
                    OP_JAL:                    next = S_JAL;
                    default:                   next = (EXC_EN != 0) ? S_EXC : S_FETCH;
                endcase
            end
            S_MEMADR: next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  next = done ? S_MEMWB : S_MEMRD;
            S_MEMWR:  next = done ? S_FETCH : S_MEMWR;
            S_EXEC:   next = S_ALUWB;
            S_IEXEC:  next = S_IWB;
            default:  next = S_FETCH;
        endcase
    end

    // Every non-memory state leaves on the next edge, so the counter only
    // survives a clock edge while a memory state is still waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
            cnt   <= '0;
        end else begin
            state <= next;
            if (mem_state && !done) cnt <= cnt + CW'(1);
            else                    cnt <= '0;
        end
    end

    always_comb begin
        memread    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        branch     = 1'b0;
        bne        = 1'b0;
        epcwrite   = 1'b0;
        causewrite = 1'b0;
        alusrcb    = 3'b000;
        regdst     = 2'b00;
        memtoreg   = 2'b00;
        pcsrc      = 2'b00;
        aluop      = 2'b00;
        lb         = 2'b00;
        case (state)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = 3'b001;
                irwrite = done;
                pcwrite = done;
            end
            S_DECODE: alusrcb = 3'b011;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 3'b010;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                memread = 1'b1;
                lb      = lb_sel;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 2'b01;
                lb       = lb_sel;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_ALUWB: begin
                regdst   = 2'b01;
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = (op == OP_BEQ);
                bne     = (op == OP_BNE);
            end
            S_IEXEC: begin
                alusrca = 1'b1;
                case (op)
                    OP_ADDI: begin
                        alusrcb = 3'b010;
                        aluop   = 2'b00;
                    end
                    OP_ANDI, OP_ORI: begin
                        alusrcb = 3'b100;
                        aluop   = 2'b11;
                    end
                    default: ;
                endcase
            end
            S_IWB: regwrite = 1'b1;
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            S_JAL: begin
                pcsrc    = 2'b10;
                pcwrite  = 1'b1;
                regwrite = 1'b1;
                regdst   = 2'b10;
                memtoreg = 2'b10;
            end
            S_EXC: begin
                pcsrc      = 2'b11;
                pcwrite    = 1'b1;
                epcwrite   = 1'b1;
                causewrite = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: doc/maindec_ws.md
MAINDEC_WS -- requirements
Module: maindec_ws

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 0: extra wait cycles per memory access when USE_READY=0 (0 gives single-cycle access).
REQ-002 SHALL have parameter USE_READY, default 0: 1 ends memory access on mem_ready, ignoring MEM_WAIT.
REQ-003 SHALL have parameter EXC_EN, default 1: 1 routes illegal opcodes to EXC; 0 routes them to FETCH.
REQ-004 SHALL have ports as follows (clock and reset first):
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high; clock clk.
- op  in  6  opcode from instruction register, stable from DECODE until next fetch completes.
- mem_ready  in  1  memory access complete (USE_READY=1 only).
- memread, memwrite, iord, irwrite, pcwrite, regwrite, alusrca, branch, bne, epcwrite, causewrite  out  1  datapath controls.
- alusrcb  out  3  000 reg, 001 4, 010 signimm, 011 signimm<<2, 100 zeroimm.
- regdst, memtoreg, pcsrc, aluop, lb  out  2 each.
- busy  out  1  a memory-access state is waiting.
- st  out  4  current state code.

Function
REQ-005 SHALL encode states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, IEXEC=9, IWB=10, JUMP=11, JAL=12, EXC=13; codes 14-15 SHALL go to FETCH with all outputs 0.
REQ-006 Memory-access states SHALL be FETCH, MEMRD and MEMWR; each SHALL be held until done, then advance.
REQ-007 done SHALL be mem_ready when USE_READY=1, else wait counter == MEM_WAIT.
REQ-008 The wait counter SHALL be $clog2(MEM_WAIT+1) bits (minimum 1), increment each non-done cycle in a memory-access state, and clear to 0 on every state change.
REQ-009 busy SHALL be 1 in a memory-access state when done=0.
REQ-010 Transitions:
- FETCH -> DECODE.
- DECODE by op: 000000 -> EXEC; 100011, 101011, 100000, 100100 -> MEMADR; 000100, 000101 -> BRANCH; 001000, 001100, 001101 -> IEXEC; 000010 -> JUMP; 000011 -> JAL; any other op -> EXC (EXC_EN=1) or FETCH (EXC_EN=0).
- MEMADR -> MEMWR for 101011, else MEMRD.
- MEMRD -> MEMWB; EXEC -> ALUWB; IEXEC -> IWB.
- MEMWB, MEMWR, ALUWB, IWB, BRANCH, JUMP, JAL, EXC -> FETCH.
REQ-011 All outputs SHALL be 0 unless listed here:
- FETCH: memread=1, alusrcb=001; irwrite=1 and pcwrite=1 only in the done cycle.
- DECODE: alusrcb=011.
- MEMADR: alusrca=1, alusrcb=010.
- MEMRD: iord=1, memread=1, lb=00 (lw) / 01 (100000) / 10 (100100).
- MEMWB: regwrite=1, memtoreg=01, lb as in MEMRD.
- MEMWR: iord=1, memwrite=1 for every cycle in the state.
- EXEC: alusrca=1, aluop=10.
- ALUWB: regdst=01, regwrite=1.
- BRANCH: alusrca=1, aluop=01, pcsrc=01; branch=1 for op 000100, bne=1 for op 000101.
- IEXEC: alusrca=1; addi alusrcb=010, aluop=00; andi/ori alusrcb=100, aluop=11.
- IWB: regwrite=1.
- JUMP: pcsrc=10, pcwrite=1.
- JAL: pcsrc=10, pcwrite=1, regwrite=1, regdst=10, memtoreg=10.
- EXC: pcsrc=11, pcwrite=1, epcwrite=1, causewrite=1.
REQ-012 Outputs SHALL be a pure function of state, op and done (Moore plus done-gated strobes); st SHALL equal the state code.

Reset
REQ-013 reset SHALL force FETCH and a wait counter of 0 immediately, including mid-wait; while reset is high all outputs SHALL be FETCH values with irwrite=pcwrite=0 unless done.
REQ-014 After reset release, the first rising edge SHALL evaluate FETCH normally.

Verification
REQ-015 Defaults, lw 100011: st sequence 0,1,2,3,4,0; MEMWB has regwrite=1, memtoreg=01; fetch takes 1 cycle.
REQ-016 MEM_WAIT=2, sw 101011: FETCH lasts 3 cycles with busy=1,1,0 and irwrite only in cycle 3; MEMWR lasts 3 cycles with memwrite=1 throughout.
REQ-017 USE_READY=1, mem_ready low for 4 cycles then high: FETCH lasts 5 cycles and pcwrite pulses once.
REQ-018 jal 000011: DECODE then JAL with regdst=10, memtoreg=10, pcwrite=1, then FETCH; ori 001101: IEXEC alusrcb=100, aluop=11, then IWB.
REQ-019 op 111111: EXC_EN=1 gives DECODE -> EXC (pcsrc=11, epcwrite=1) -> FETCH; EXC_EN=0 gives DECODE -> FETCH.
REQ-020 reset asserted in cycle 2 of a MEM_WAIT=3 MEMRD gives st=0 asynchronously; after release, FETCH lasts the full 4 cycles.
